game_status: RTL
================

GAME_STATUS -- requirements
Module: game_status

Interface
REQ-001 SHALL provide parameter LIVES_INIT, default 3, the number of lives at game start (range 1..7).
REQ-002 SHALL provide parameter WIN_SCORE, default 8'h50, the packed-BCD score at which the game is won.
REQ-003 SHALL provide parameter GRACE_CYCLES, default 1000, the number of cycles collisions are ignored after a non-fatal hit.
REQ-004 iClk  input  1  system clock.
REQ-005 iRst_n  input  1  reset; asynchronous, active-low.
REQ-006 iState  input  3  top-level game state, encoded with the shared `STATE_START / `STATE_INGAME / `STATE_WON / `STATE_OVER macros.
REQ-007 iFood_eaten  input  1  one-cycle pulse when the player scores one point.
REQ-008 iCollision  input  1  level, high while the player touches a hazard.
REQ-009 oGame_won  output  1  sticky win flag, consumed by the game state machine.
REQ-010 oGame_over  output  1  sticky loss flag, consumed by the game state machine.
REQ-011 oScore  output  8  current score, packed BCD (tens in [7:4], ones in [3:0]).
REQ-012 oHigh_score  output  8  best final score since reset, packed BCD.
REQ-013 oLives  output  3  remaining lives.
REQ-014 oGrace  output  1  high while the invulnerability window is active.

Function
REQ-015 SHALL implement the internal states IDLE, PLAY, GRACE and DONE; all outputs SHALL be registered.
REQ-016 IDLE -> PLAY on the first cycle iState==`STATE_INGAME: oScore<=8'h00, oLives<=LIVES_INIT, flags stay 0.
REQ-017 In PLAY, an iFood_eaten pulse SHALL increment oScore by 1 in BCD on the next cycle: ones 9 -> 0 with tens +1; saturate at 8'h99.
REQ-018 In PLAY, a rising edge of iCollision (registered copy 0, input 1) SHALL decrement oLives by 1 on the next cycle; a level held high SHALL NOT cause further decrements.
REQ-019 After a non-fatal hit (oLives > 0 after the decrement), the block SHALL enter GRACE with oGrace=1 for exactly GRACE_CYCLES cycles, then return to PLAY.
REQ-020 In GRACE, collisions SHALL be ignored; food SHALL still be counted.
REQ-021 After a fatal hit (oLives reaches 0), the block SHALL enter DONE with oGame_over=1 one cycle after the collision edge.
REQ-022 When the updated oScore equals WIN_SCORE, the block SHALL enter DONE with oGame_won=1 in the same cycle the score is updated.
REQ-023 When food and a collision arrive in the same cycle, both SHALL be applied; if both win and loss result, oGame_over SHALL win and oGame_won SHALL stay 0.
REQ-024 On entry to DONE, the block SHALL set oHigh_score<=oScore' if the final score is greater than oHigh_score (BCD compare equals unsigned compare).
REQ-025 In DONE, inputs SHALL be ignored and the flags SHALL be held until iState==`STATE_START.
REQ-026 iState==`STATE_START in any state SHALL force IDLE next cycle and clear oGame_won, oGame_over and oGrace; oScore and oLives SHALL retain their last values for display.
REQ-027 If iState leaves `STATE_INGAME for any value other than START while in PLAY or GRACE, the block SHALL go to DONE without setting either flag and without updating the high score.
REQ-028 The GRACE counter SHALL be sized as $clog2(GRACE_CYCLES+1) bits and SHALL reset to 0 on every GRACE entry.

Reset
REQ-029 Reset SHALL be asynchronous on iRst_n low: state IDLE; oScore, oHigh_score 8'h00; oLives LIVES_INIT; oGame_won, oGame_over, oGrace 0; grace counter and collision edge register 0.
REQ-030 Reset asserted mid-game SHALL abort immediately, with no flag pulse on release; oHigh_score SHALL be lost.

Verification
REQ-031 iState=INGAME, then 9 food pulses, then 1 more -> oScore 8'h09, then 8'h10 on the cycle after the 10th pulse.
REQ-032 LIVES_INIT=3, GRACE_CYCLES=4: collision high for 10 cycles -> oLives 2, oGrace high exactly 4 cycles, no second decrement; a new collision edge after the window -> oLives 1.
REQ-033 oLives=1 with a collision edge -> oGame_over=1 one cycle later, held until iState=START, then 0 next cycle; oHigh_score updated if the score is higher.
REQ-034 WIN_SCORE=8'h03: 3 food pulses -> oGame_won=1 with oScore=8'h03; a repeat with food and a fatal collision in the same cycle -> oGame_over=1, oGame_won=0.
REQ-035 Score at 8'h99 plus food -> remains 8'h99 (with WIN_SCORE set above reach, e.g. 8'hA0).
REQ-036 iRst_n pulsed low mid-PLAY with oScore=8'h25 -> all outputs return to reset values asynchronously; the next INGAME starts from score 0, lives 3.

Source files
------------

// File: rtl/game_status.sv
// -----------------------------------------------------------------------------
// game_status
// Tracks score, lives, high score and the post-hit invulnerability window for
// one game session. It raises sticky win/loss flags for the top-level game
// state machine.
//
// Parameters
//   LIVES_INIT   lives at game start (1..7)
//   WIN_SCORE    packed-BCD score that wins the game
//   GRACE_CYCLES cycles collisions are ignored after a non-fatal hit
//
// Ports
//   iClk         system clock
//   iRst_n       asynchronous active-low reset
//   iState       top-level game state (`STATE_START/INGAME/WON/OVER)
//   iFood_eaten  one-cycle pulse, +1 point
//   iCollision   level, high while touching a hazard
//   oGame_won    sticky win flag
//   oGame_over   sticky loss flag
//   oScore       current score, packed BCD
//   oHigh_score  best final score since reset, packed BCD
//   oLives       remaining lives
//   oGrace       invulnerability window active
// -----------------------------------------------------------------------------
`ifndef STATE_START
`define STATE_START  3'd0
`endif
`ifndef STATE_INGAME
`define STATE_INGAME 3'd1
`endif
`ifndef STATE_WON
`define STATE_WON    3'd2
`endif
`ifndef STATE_OVER
`define STATE_OVER   3'd3
`endif

module game_status #(
    parameter int          LIVES_INIT   = 3,
    parameter logic [7:0]  WIN_SCORE    = 8'h50,
    parameter int          GRACE_CYCLES = 1000
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [2:0] iState,
    input  logic       iFood_eaten,
    input  logic       iCollision,
    output logic       oGame_won,
    output logic       oGame_over,
    output logic [7:0] oScore,
    output logic [7:0] oHigh_score,
    output logic [2:0] oLives,
    output logic       oGrace
);

    localparam int CW = $clog2(GRACE_CYCLES + 1);
    localparam logic [CW-1:0] GRACE_LAST = CW'(GRACE_CYCLES - 1);
    localparam logic [2:0]    LIVES_START = 3'(LIVES_INIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        GRACE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_r;
    logic [CW-1:0] graceCnt_r;
    logic          collPrev_r;

    logic [7:0]    nextScore_s;
    logic [2:0]    nextLives_s;
    logic          hit_s;
    logic          fatal_s;
    logic          win_s;

    // Packed-BCD increment saturating at 99.
    function automatic logic [7:0] bcdInc(input logic [7:0] val);
        logic [7:0] res;
        if (val == 8'h99) begin
            res = 8'h99;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

    // Next score/lives and the terminal-event decode for the current cycle.
    always_comb begin
        nextScore_s = oScore;
        nextLives_s = oLives;
        hit_s       = 1'b0;
        if (iFood_eaten) begin
            nextScore_s = bcdInc(oScore);
        end else begin
            nextScore_s = oScore;
        end
        // Only a rising edge counts, and only outside the grace window.
        if ((state_r == PLAY) && iCollision && !collPrev_r) begin
            hit_s       = 1'b1;
            nextLives_s = oLives - 3'd1;
        end else begin
            hit_s       = 1'b0;
            nextLives_s = oLives;
        end
        fatal_s = hit_s && (nextLives_s == 3'd0);
        win_s   = iFood_eaten && (nextScore_s == WIN_SCORE);
    end

    // Session state machine with all outputs registered.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_r     <= IDLE;
            graceCnt_r  <= '0;
            collPrev_r  <= 1'b0;
            oGame_won   <= 1'b0;
            oGame_over  <= 1'b0;
            oScore      <= 8'h00;
            oHigh_score <= 8'h00;
            oLives      <= LIVES_START;
            oGrace      <= 1'b0;
        end else begin
            collPrev_r <= iCollision;
            if (iState == `STATE_START) begin
                // Score and lives stay visible for the start screen.
                state_r    <= IDLE;
                oGame_won  <= 1'b0;
                oGame_over <= 1'b0;
                oGrace     <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (iState == `STATE_INGAME) begin
                            state_r <= PLAY;
                            oScore  <= 8'h00;
                            oLives  <= LIVES_START;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    PLAY, GRACE: begin
                        if (iState != `STATE_INGAME) begin
                            // Aborted externally: no flags, no high score.
                            state_r <= DONE;
                            oGrace  <= 1'b0;
                        end else begin
                            oScore <= nextScore_s;
                            oLives <= nextLives_s;
                            // Loss takes priority over a simultaneous win.
                            if (fatal_s || win_s) begin
                                state_r    <= DONE;
                                oGrace     <= 1'b0;
                                oGame_over <= fatal_s;
                                oGame_won  <= !fatal_s;
                                if (nextScore_s > oHigh_score) begin
                                    oHigh_score <= nextScore_s;
                                end else begin
                                    oHigh_score <= oHigh_score;
                                end
                            end else if (hit_s) begin
                                state_r    <= GRACE;
                                oGrace     <= 1'b1;
                                graceCnt_r <= '0;
                            end else if (state_r == GRACE) begin
                                if (graceCnt_r == GRACE_LAST) begin
                                    state_r <= PLAY;
                                    oGrace  <= 1'b0;
                                end else begin
                                    graceCnt_r <= graceCnt_r + {{(CW-1){1'b0}}, 1'b1};
                                end
                            end else begin
                                state_r <= PLAY;
                            end
                        end
                    end
                    DONE: begin
                        state_r <= DONE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
